muldiv_sched: RTL and testbench
===============================

Name: muldiv_sched

Overview:
- Scheduler for the multi-cycle HI/LO multiply/divide unit in the 5-stage pipeline.
- Issues a start pulse to the unit when a mult/div reaches ID, then counts the fixed latency.
- Raises hilo_we_o for exactly one cycle at completion.
- Stalls ID while a later mult/div or mfhi/mflo would conflict. Stall outputs are ANDed/ORed externally with the load-use hazard outputs.

Parameters:
- MUL_LAT, 4, cycles from start to result-valid for mult/multu; legal range 2..(2^CNT_W).
- DIV_LAT, 16, cycles from start to result-valid for div/divu; legal range 2..(2^CNT_W).
- CNT_W, 5, width of the latency down-counter.
- STAT_W, 16, width of the saturating stall-cycle statistic.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- id_md_req_i  in  1  instruction in ID is mult/multu/div/divu.
- id_md_op_i  in  1  0 = multiply, 1 = divide; valid with id_md_req_i.
- id_hilo_rd_i  in  1  instruction in ID is mfhi/mflo.
- branch_flush_i  in  1  taken branch this cycle; the ID instruction is squashed.
- lu_stall_i  in  1  load-use stall from the hazard unit this cycle.
- md_start_o  out  1  one-cycle start pulse to the multiply/divide unit.
- md_op_o  out  1  operation latched at start; held stable while busy.
- hilo_we_o  out  1  HI/LO write enable, one cycle.
- busy_o  out  1  state != IDLE.
- PC_Write_o  out  1  0 = hold PC.
- IF_Write_o  out  1  0 = hold the IF/ID register.
- ID_Flush_o  out  1  1 = insert a bubble into ID/EX.
- stall_cnt_o  out  STAT_W  number of cycles this block stalled; saturates at all-ones.

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - state = IDLE, cnt = 0, md_op_o = 0, hilo_we_o = 0, stall_cnt_o = 0.
  - Combinational outputs then read: md_start_o = 0, busy_o = 0, PC_Write_o = 1, IF_Write_o = 1, ID_Flush_o = 0.
- States: IDLE, BUSY, WB. Encoding is free.
- accept = (state == IDLE) & id_md_req_i & ~branch_flush_i & ~lu_stall_i.
- md_start_o = accept (combinational, same cycle).
- On accept:
  - md_op_o <= id_md_op_i.
  - cnt <= (id_md_op_i ? DIV_LAT : MUL_LAT) - 1.
  - state <= BUSY.
- BUSY:
  - If cnt == 1: state <= WB. Otherwise cnt <= cnt - 1.
  - hilo_we_o is registered and asserted during the WB cycle.
  - Start-to-hilo_we_o latency is exactly LAT cycles: start in cycle t, hilo_we_o high in cycle t+LAT.
- WB: hilo_we_o = 1; state <= IDLE unconditionally. A new request is not accepted in WB.
- conflict = (state != IDLE) & (id_md_req_i | id_hilo_rd_i).
- stall = conflict & ~branch_flush_i.
- When stall = 1: PC_Write_o = 0, IF_Write_o = 0, ID_Flush_o = 1. Otherwise PC_Write_o = 1, IF_Write_o = 1, ID_Flush_o = 0.
- Independent instructions (neither flag set) pass freely while BUSY; HI/LO is private to this unit.
- mfhi/mflo in ID during the WB cycle still stalls. It reads HI/LO the cycle after WB, in IDLE.
- Back-to-back mult/div:
  - The second request stalls through BUSY and WB.
  - It is accepted in the first IDLE cycle.
  - Minimum start-to-start interval is LAT+1.
- Simultaneous events:
  - branch_flush_i has priority: no accept, no stall. A running operation continues, since it belongs to an older, committed instruction.
  - lu_stall_i in IDLE blocks accept. The ID instruction is re-presented next cycle.
  - lu_stall_i while BUSY does not change the counter.
- stall_cnt_o increments by 1 in every cycle with stall = 1; it holds at 2^STAT_W - 1.
- Reset mid-operation aborts immediately: state IDLE, no hilo_we_o pulse is issued.

Test Plan:
- Reset, then mult in ID at cycle 2 (MUL_LAT = 4) -> md_start_o = 1 at cycle 2, busy_o cycles 3-6, hilo_we_o = 1 only at cycle 6, md_op_o = 0 throughout.
- div at cycle 2, mflo in ID from cycle 3 (DIV_LAT = 16) -> PC_Write_o = 0, IF_Write_o = 0, ID_Flush_o = 1 for cycles 3-18, released at cycle 19, stall_cnt_o = 16.
- Two consecutive mults at cycles 2 and 3 -> second is stalled cycles 3-6, md_start_o second pulse at cycle 7, hilo_we_o at cycles 6 and 11.
- mult in ID with branch_flush_i = 1 in the same IDLE cycle -> md_start_o = 0, busy_o stays 0, no stall; repeat with lu_stall_i = 1 -> no start, start next cycle once lu_stall_i = 0.
- div started, add/sub instructions flowing in ID -> no stall on any cycle; hilo_we_o exactly 16 cycles after start.
- div started, rst_i low at BUSY cycle 5 -> busy_o = 0 and stall outputs released asynchronously, no hilo_we_o pulse; next mult after reset release behaves as in scenario 1.

Source files
------------

// File: rtl/muldiv_sched.sv
// Scheduler for the multi-cycle HI/LO multiply/divide unit.
// It starts the unit when a mult/div reaches ID and then counts the fixed latency.
// It pulses the HI/LO write enable at completion.
// It stalls ID while a later mult/div or mfhi/mflo would conflict with the running operation.
module muldiv_sched #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 5,
    parameter int STAT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_md_req_i,
    input  logic              id_md_op_i,
    input  logic              id_hilo_rd_i,
    input  logic              branch_flush_i,
    input  logic              lu_stall_i,
    output logic              md_start_o,
    output logic              md_op_o,
    output logic              hilo_we_o,
    output logic              busy_o,
    output logic              PC_Write_o,
    output logic              IF_Write_o,
    output logic              ID_Flush_o,
    output logic [STAT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

    // The counter is loaded with LAT-1, so the last BUSY cycle sees cnt == 1.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             conflict;
    logic             stall;

    // Saturating increment for the stall statistic.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A flushed instruction neither starts nor stalls; a running operation is never cancelled by it.
    always_comb begin
        accept      = (state == IDLE) & id_md_req_i & ~branch_flush_i & ~lu_stall_i;
        conflict    = (state != IDLE) & (id_md_req_i | id_hilo_rd_i);
        stall       = conflict & ~branch_flush_i;
        md_start_o  = accept;
        busy_o      = (state != IDLE);
        PC_Write_o  = ~stall;
        IF_Write_o  = ~stall;
        ID_Flush_o  = stall;
    end

    // Operation sequencing: IDLE -> BUSY (latency count) -> WB (one write cycle) -> IDLE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            md_op_o   <= 1'b0;
            hilo_we_o <= 1'b0;
        end else begin
            hilo_we_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        md_op_o <= id_md_op_i;
                        cnt     <= id_md_op_i ? DIV_CNT : MUL_CNT;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state     <= WB;
                        hilo_we_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Count every cycle in which this block holds the front of the pipeline.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall) begin
            stall_cnt_o <= sat_inc(stall_cnt_o);
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Testbench for muldiv_sched.
// Applies directed scenarios followed by random traffic.
// A cycle-number reference model predicts every output.
module tb_muldiv_sched;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;
    localparam int CNT_W   = 5;
    localparam int STAT_W  = 6;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              id_md_req_i = 1'b0;
    logic              id_md_op_i = 1'b0;
    logic              id_hilo_rd_i = 1'b0;
    logic              branch_flush_i = 1'b0;
    logic              lu_stall_i = 1'b0;
    logic              md_start_o;
    logic              md_op_o;
    logic              hilo_we_o;
    logic              busy_o;
    logic              PC_Write_o;
    logic              IF_Write_o;
    logic              ID_Flush_o;
    logic [STAT_W-1:0] stall_cnt_o;

    muldiv_sched #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (CNT_W),
        .STAT_W (STAT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_md_req_i   (id_md_req_i),
        .id_md_op_i    (id_md_op_i),
        .id_hilo_rd_i  (id_hilo_rd_i),
        .branch_flush_i(branch_flush_i),
        .lu_stall_i    (lu_stall_i),
        .md_start_o    (md_start_o),
        .md_op_o       (md_op_o),
        .hilo_we_o     (hilo_we_o),
        .busy_o        (busy_o),
        .PC_Write_o    (PC_Write_o),
        .IF_Write_o    (IF_Write_o),
        .ID_Flush_o    (ID_Flush_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Model state: cycle number of the pending write-back (-1 when none), latched op, stall count.
    int cyc     = 0;
    int wb_cyc  = -1;
    bit m_op    = 1'b0;
    int m_scnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic void model_reset();
        wb_cyc = -1;
        m_op   = 1'b0;
        m_scnt = 0;
    endfunction

    // One clock cycle: drive ID inputs, check all outputs mid-cycle, then advance the model.
    task automatic cycle(input bit req, input bit op, input bit rd, input bit fl, input bit lu);
        bit active, exp_we, exp_stall, exp_acc;
        @(negedge clk_i);
        cyc++;
        id_md_req_i    = req;
        id_md_op_i     = op;
        id_hilo_rd_i   = rd;
        branch_flush_i = fl;
        lu_stall_i     = lu;
        #1;
        active    = (wb_cyc >= 0) && (cyc <= wb_cyc);
        exp_we    = (cyc == wb_cyc);
        exp_stall = active && (req || rd) && !fl;
        exp_acc   = !active && req && !fl && !lu;
        chk("md_start", 32'(md_start_o), 32'(exp_acc));
        chk("busy", 32'(busy_o), 32'(active));
        chk("hilo_we", 32'(hilo_we_o), 32'(exp_we));
        chk("md_op", 32'(md_op_o), 32'(m_op));
        chk("pc_write", 32'(PC_Write_o), 32'(!exp_stall));
        chk("if_write", 32'(IF_Write_o), 32'(!exp_stall));
        chk("id_flush", 32'(ID_Flush_o), 32'(exp_stall));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(m_scnt));
        if (exp_acc) begin
            wb_cyc = cyc + (op ? DIV_LAT : MUL_LAT);
            m_op   = op;
        end
        if (exp_stall && m_scnt < STAT_MAX) m_scnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear with no clock edge.
    task automatic apply_reset();
        @(negedge clk_i);
        id_md_req_i  = 1'b0;
        id_hilo_rd_i = 1'b1;
        #2;
        rst_i = 1'b0;
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_hilo_we", 32'(hilo_we_o), 32'd0);
        chk("rst_md_op", 32'(md_op_o), 32'd0);
        chk("rst_md_start", 32'(md_start_o), 32'd0);
        chk("rst_pc_write", 32'(PC_Write_o), 32'd1);
        chk("rst_if_write", 32'(IF_Write_o), 32'd1);
        chk("rst_id_flush", 32'(ID_Flush_o), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        id_hilo_rd_i = 1'b0;
        rst_i = 1'b1;
    endtask

    initial begin
        // Scenario 1: single mult.
        apply_reset();
        cyc = 0;
        idle(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Scenario 2: div followed by mflo held in ID.
        apply_reset();
        idle(1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("div_mflo_stall_total", 32'(stall_cnt_o), 32'd16);
        idle(2);

        // Scenario 3: back-to-back mults; the second stays in ID until accepted.
        apply_reset();
        idle(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);
        chk("b2b_stall_total", 32'(stall_cnt_o), 32'd4);

        // Scenario 4: flush and load-use stall block the start.
        apply_reset();
        idle(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_no_busy", 32'(busy_o), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Scenario 5: div with independent instructions, flushes and load-use stalls around it.
        apply_reset();
        idle(1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++)
            cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("indep_no_stall", 32'(stall_cnt_o), 32'd0);

        // Scenario 6: reset in the middle of a div.
        apply_reset();
        idle(1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        @(negedge clk_i);
        id_hilo_rd_i = 1'b1;
        #1;
        chk("midop_stalling", 32'(ID_Flush_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("midop_busy", 32'(busy_o), 32'd0);
        chk("midop_id_flush", 32'(ID_Flush_o), 32'd0);
        chk("midop_pc_write", 32'(PC_Write_o), 32'd1);
        chk("midop_if_write", 32'(IF_Write_o), 32'd1);
        model_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            chk("midop_no_hilo_we", 32'(hilo_we_o), 32'd0);
        end
        id_hilo_rd_i = 1'b0;
        rst_i = 1'b1;
        idle(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Random traffic; the narrow statistic saturates along the way.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 7) == 0));
        end
        chk("stat_saturated", 32'(stall_cnt_o), 32'(STAT_MAX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
